// File: rtl/control_sequencer.sv
// control_sequencer: microcode step sequencer for the 8-bit CPU.
// Steps IDLE -> T0..T4 -> T0 and drives a registered 16-bit strobe word onto
// the register, PC, MAR, RAM, ALU and OUT blocks sharing BUSA.
// Optional single-step mode: define CONTROL_SEQUENCER_SINGLE_STEP_EN to add
// STEP_MODE/STEP_REQ; without it the sequencer is always free-running.
module control_sequencer #(
  parameter bit HALT_ON_UNDEF = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  IR_IN,
  input  logic        FLAG_C,
  input  logic        FLAG_Z,
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
  input  logic        STEP_MODE,
  input  logic        STEP_REQ,
`endif
  output logic [15:0] CTRL,
  output logic [2:0]  STEP,
  output logic        HALTED
);

  // Strobe bits of the control word
  localparam logic [15:0] PC_INC     = 16'h0001;
  localparam logic [15:0] PC_EN      = 16'h0002;
  localparam logic [15:0] PC_LATCH   = 16'h0004;
  localparam logic [15:0] MAR_LATCH  = 16'h0008;
  localparam logic [15:0] RAM_EN     = 16'h0010;
  localparam logic [15:0] RAM_LATCH  = 16'h0020;
  localparam logic [15:0] IR_LATCH   = 16'h0040;
  localparam logic [15:0] IR_EN      = 16'h0080;
  localparam logic [15:0] A_LATCH    = 16'h0100;
  localparam logic [15:0] A_EN       = 16'h0200;
  localparam logic [15:0] B_LATCH    = 16'h0400;
  localparam logic [15:0] ALU_EN     = 16'h0800;
  localparam logic [15:0] ALU_SUB    = 16'h1000;
  localparam logic [15:0] OUT_LATCH  = 16'h2000;
  localparam logic [15:0] FLAG_LATCH = 16'h4000;
  localparam logic [15:0] HALT_BIT   = 16'h8000;

  // Fetch words shared by every instruction
  localparam logic [15:0] WORD_T0 = PC_EN | MAR_LATCH;
  localparam logic [15:0] WORD_T1 = RAM_EN | IR_LATCH | PC_INC;

  // Opcodes
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ctrl_q, ctrl_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [2:0]  step_q, step_d;
  logic        halted_q, halted_d;
  logic        advance;

  // The operand nibble is driven onto the bus by the IR itself, so it is not
  // needed here; folding it into a named sink documents that it is ignored.
  logic        unusedOperand;
  assign unusedOperand = ^IR_IN[3:0];

`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
  logic reqMeta_q, reqSync_q, reqPrev_q;

  // Two-flop synchronizer plus edge detect so one button press is one advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reqMeta_q <= 1'b0;
      reqSync_q <= 1'b0;
      reqPrev_q <= 1'b0;
    end else begin
      reqMeta_q <= STEP_REQ;
      reqSync_q <= reqMeta_q;
      reqPrev_q <= reqSync_q;
    end
  end

  assign advance = !STEP_MODE || (reqSync_q && !reqPrev_q);
`else
  assign advance = 1'b1;
`endif

  // Next state and the control word that belongs to that next state
  always_comb begin
    state_d  = state_q;
    ctrl_d   = 16'h0000;
    opcode_d = opcode_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_T0;
        ctrl_d  = WORD_T0;
      end
      S_T0: begin
        state_d = S_T1;
        ctrl_d  = WORD_T1;
      end
      S_T1: begin
        // IR is transparent during T1, so the opcode and flags are valid here
        opcode_d = IR_IN[7:4];
        state_d  = S_T2;
        case (IR_IN[7:4])
          OP_NOP:                         ctrl_d = 16'h0000;
          OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl_d = IR_EN | MAR_LATCH;
          OP_LDI:                         ctrl_d = IR_EN | A_LATCH;
          OP_JMP:                         ctrl_d = IR_EN | PC_LATCH;
          OP_JC:                          ctrl_d = FLAG_C ? (IR_EN | PC_LATCH) : 16'h0000;
          OP_JZ:                          ctrl_d = FLAG_Z ? (IR_EN | PC_LATCH) : 16'h0000;
          OP_OUT:                         ctrl_d = A_EN | OUT_LATCH;
          OP_HLT: begin
            state_d = S_HALT;
            ctrl_d  = HALT_BIT;
          end
          default: begin
            if (HALT_ON_UNDEF) begin
              state_d = S_HALT;
              ctrl_d  = HALT_BIT;
            end else begin
              ctrl_d  = 16'h0000;
            end
          end
        endcase
      end
      S_T2: begin
        case (opcode_q)
          OP_LDA: begin
            state_d = S_T3;
            ctrl_d  = RAM_EN | A_LATCH;
          end
          OP_ADD, OP_SUB: begin
            state_d = S_T3;
            ctrl_d  = RAM_EN | B_LATCH;
          end
          OP_STA: begin
            state_d = S_T3;
            ctrl_d  = A_EN | RAM_LATCH;
          end
          default: begin
            state_d = S_T0;
            ctrl_d  = WORD_T0;
          end
        endcase
      end
      S_T3: begin
        if (opcode_q == OP_ADD || opcode_q == OP_SUB) begin
          state_d = S_T4;
          ctrl_d  = ALU_EN | A_LATCH | FLAG_LATCH;
          if (opcode_q == OP_SUB) begin
            ctrl_d = ctrl_d | ALU_SUB;
          end
        end else begin
          state_d = S_T0;
          ctrl_d  = WORD_T0;
        end
      end
      S_T4: begin
        state_d = S_T0;
        ctrl_d  = WORD_T0;
      end
      S_HALT: begin
        state_d = S_HALT;
        ctrl_d  = HALT_BIT;
      end
      default: begin
        state_d = S_IDLE;
        ctrl_d  = 16'h0000;
      end
    endcase
  end

  // STEP and HALTED are decoded from the next state so they register alongside CTRL
  always_comb begin
    step_d   = 3'd0;
    halted_d = 1'b0;
    case (state_d)
      S_T1:    step_d = 3'd1;
      S_T2:    step_d = 3'd2;
      S_T3:    step_d = 3'd3;
      S_T4:    step_d = 3'd4;
      S_HALT:  halted_d = 1'b1;
      default: step_d = 3'd0;
    endcase
  end

  // State and strobe registers; when held in single-step the strobes are blanked
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= 16'h0000;
      opcode_q <= 4'h0;
      step_q   <= 3'd0;
      halted_q <= 1'b0;
    end else if (advance) begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      opcode_q <= opcode_d;
      step_q   <= step_d;
      halted_q <= halted_d;
    end else begin
      ctrl_q   <= 16'h0000;
    end
  end

  assign CTRL   = ctrl_q;
  assign STEP   = step_q;
  assign HALTED = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: two instances (undefined opcodes as NOP and
// as HALT) share random stimulus and are checked every cycle against a
// per-instruction microcode table model.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irIn;
  logic        flagC;
  logic        flagZ;
  logic [15:0] ctrl0, ctrl1;
  logic [2:0]  step0, step1;
  logic        halted0, halted1;

  int checkCount = 0;
  int failCount  = 0;

  // Reference model state, one slot per instance
  bit          mIdle[2];
  bit          mHalted[2];
  int          mPos[2];
  int          mLen[2];
  logic [15:0] mWords[2][3];
  logic [15:0] expCtrl[2];
  int          expStep[2];
  bit          expHalted[2];
  bit          justDecoded;

  // Directed instructions {ir, flagC, flagZ} applied before random traffic
  localparam int NDIR = 13;
  logic [9:0] dirList[NDIR];
  int dirIdx = 0;

  int haltCycles = 0;
  int rstLeft    = 1;

  // 10 ns clock
  always #5 clk = ~clk;

  control_sequencer #(.HALT_ON_UNDEF(1'b0)) dut0 (
    .clk    (clk),
    .reset  (reset),
    .IR_IN  (irIn),
    .FLAG_C (flagC),
    .FLAG_Z (flagZ),
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
    .STEP_MODE (1'b0),
    .STEP_REQ  (1'b0),
`endif
    .CTRL   (ctrl0),
    .STEP   (step0),
    .HALTED (halted0)
  );

  control_sequencer #(.HALT_ON_UNDEF(1'b1)) dut1 (
    .clk    (clk),
    .reset  (reset),
    .IR_IN  (irIn),
    .FLAG_C (flagC),
    .FLAG_Z (flagZ),
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
    .STEP_MODE (1'b0),
    .STEP_REQ  (1'b0),
`endif
    .CTRL   (ctrl1),
    .STEP   (step1),
    .HALTED (halted1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checkCount++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  // Execute words per opcode, written out as hex constants from the strobe map
  task automatic microcode(input logic [3:0] op, input logic c, input logic z, input bit hou,
                           output logic [15:0] w0, output logic [15:0] w1, output logic [15:0] w2,
                           output int len, output bit halts);
    w0 = 16'h0000; w1 = 16'h0000; w2 = 16'h0000; len = 1; halts = 1'b0;
    case (op)
      4'h0: len = 1;
      4'h1: begin w0 = 16'h0088; w1 = 16'h0110; len = 2; end
      4'h2: begin w0 = 16'h0088; w1 = 16'h0410; w2 = 16'h4900; len = 3; end
      4'h3: begin w0 = 16'h0088; w1 = 16'h0410; w2 = 16'h5900; len = 3; end
      4'h4: begin w0 = 16'h0088; w1 = 16'h0220; len = 2; end
      4'h5: w0 = 16'h0180;
      4'h6: w0 = 16'h0084;
      4'h7: w0 = c ? 16'h0084 : 16'h0000;
      4'h8: w0 = z ? 16'h0084 : 16'h0000;
      4'hE: w0 = 16'h2200;
      4'hF: halts = 1'b1;
      default: halts = hou;
    endcase
  endtask

  task automatic setExp(input int k, input logic [15:0] w, input int s, input bit h);
    expCtrl[k]   = w;
    expStep[k]   = s;
    expHalted[k] = h;
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mIdle[k]   = 1'b1;
      mHalted[k] = 1'b0;
      mPos[k]    = 0;
      setExp(k, 16'h0000, 0, 1'b0);
    end
  endtask

  // One clock edge of the model for instance k; mPos is the current Tn index
  task automatic modelEdge(input int k, input bit hou);
    logic [15:0] w0, w1, w2;
    int len;
    bit halts;
    if (mIdle[k]) begin
      mIdle[k] = 1'b0;
      mPos[k]  = 0;
      setExp(k, 16'h000A, 0, 1'b0);
    end else if (mHalted[k]) begin
      setExp(k, 16'h8000, 0, 1'b1);
    end else if (mPos[k] == 0) begin
      mPos[k] = 1;
      setExp(k, 16'h0051, 1, 1'b0);
    end else if (mPos[k] == 1) begin
      microcode(irIn[7:4], flagC, flagZ, hou, w0, w1, w2, len, halts);
      if (k == 0) justDecoded = 1'b1;
      if (halts) begin
        mHalted[k] = 1'b1;
        setExp(k, 16'h8000, 0, 1'b1);
      end else begin
        mWords[k][0] = w0;
        mWords[k][1] = w1;
        mWords[k][2] = w2;
        mLen[k]  = len;
        mPos[k]  = 2;
        setExp(k, w0, 2, 1'b0);
      end
    end else if (mPos[k] - 1 < mLen[k]) begin
      mPos[k] = mPos[k] + 1;
      setExp(k, mWords[k][mPos[k] - 2], mPos[k], 1'b0);
    end else begin
      mPos[k] = 0;
      setExp(k, 16'h000A, 0, 1'b0);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput($sformatf("%s ctrl0", tag), {16'h0, ctrl0}, {16'h0, expCtrl[0]});
    checkOutput($sformatf("%s step0", tag), {29'h0, step0}, expStep[0]);
    checkOutput($sformatf("%s halted0", tag), {31'h0, halted0}, {31'h0, expHalted[0]});
    checkOutput($sformatf("%s ctrl1", tag), {16'h0, ctrl1}, {16'h0, expCtrl[1]});
    checkOutput($sformatf("%s step1", tag), {29'h0, step1}, expStep[1]);
    checkOutput($sformatf("%s halted1", tag), {31'h0, halted1}, {31'h0, expHalted[1]});
  endtask

  task automatic applyStimulus();
    if (dirIdx < NDIR) begin
      irIn  = dirList[dirIdx][9:2];
      flagC = dirList[dirIdx][1];
      flagZ = dirList[dirIdx][0];
    end else begin
      irIn  = 8'($urandom_range(0, 255));
      flagC = 1'($urandom_range(0, 1));
      flagZ = 1'($urandom_range(0, 1));
    end
  endtask

  // Main sequence: reset, directed opcodes, then random traffic with resets
  initial begin
    dirList[0]  = {8'h5A, 1'b0, 1'b0};
    dirList[1]  = {8'h23, 1'b0, 1'b1};
    dirList[2]  = {8'h33, 1'b1, 1'b0};
    dirList[3]  = {8'h7F, 1'b1, 1'b0};
    dirList[4]  = {8'h7F, 1'b0, 1'b1};
    dirList[5]  = {8'h8F, 1'b0, 1'b1};
    dirList[6]  = {8'h8F, 1'b1, 1'b0};
    dirList[7]  = {8'h14, 1'b0, 1'b0};
    dirList[8]  = {8'h49, 1'b0, 1'b0};
    dirList[9]  = {8'hE0, 1'b0, 1'b0};
    dirList[10] = {8'h63, 1'b0, 1'b0};
    dirList[11] = {8'hA0, 1'b0, 1'b0};
    dirList[12] = {8'hF0, 1'b0, 1'b0};

    reset = 1'b1;
    justDecoded = 1'b0;
    modelReset();
    applyStimulus();
    #3;
    checkAll("resetInit");

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      justDecoded = 1'b0;
      if (!reset) begin
        modelEdge(0, 1'b0);
        modelEdge(1, 1'b1);
      end
      #1;
      checkAll("edge");
      if (justDecoded && dirIdx < NDIR) dirIdx++;
      if (mHalted[0] || mHalted[1]) haltCycles++;
      else haltCycles = 0;

      @(negedge clk);
      applyStimulus();
      if (reset) begin
        if (rstLeft == 0) reset = 1'b0;
        else rstLeft--;
      end else if (haltCycles >= 20 || $urandom_range(0, 79) == 0) begin
        #2;
        reset = 1'b1;
        modelReset();
        haltCycles = 0;
        #1;
        checkAll("asyncReset");
        rstLeft = $urandom_range(0, 2);
      end
    end

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
